interrupt_controller: RTL
=========================

# interrupt_controller

Memory-mapped Game Boy interrupt controller that sits directly upstream of the CPU core's interrupt inputs. It edge-detects the five peripheral request lines and latches them into the IF register (0xFF0F). It holds the IE register (0xFFFF) and presents both to the CPU as per-source pending lines plus the enable byte. When the CPU acknowledges service, the controller clears the highest-priority enabled pending flag.

## Interface
Parameters:
- `IF_ADDR`, default 16'hFF0F, bus address of the interrupt flag register.
- `IE_ADDR`, default 16'hFFFF, bus address of the interrupt enable register.

Ports:
- `clk` input 1: system clock; all state on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `WE` input 1: CPU write strobe.
- `RE` input 1: CPU read strobe.
- `address` input 16: CPU bus address, combinational from the CPU.
- `databus` inout 8: tri-state CPU data bus.
- `vblank_req`, `lcdc_req`, `timer_req`, `serial_req`, `joypad_req` input 1 each: level requests from peripherals.
- `int_clear` input 1: one-cycle acknowledge pulse from the CPU.
- `vblank_int`, `lcdc_int`, `timer_int`, `serial_int`, `joypad_int` output 1 each: IF bits 0..4.
- `int_en` output 8: IE register contents.

## Operation
- IF is 5 bits; bit index and priority order are vblank=0 (highest), lcdc=1, timer=2, serial=3, joypad=4 (lowest).
- IE is 8 bits. All 8 bits are stored and read back; only bits 4:0 take part in clear selection.
- Request edge detect:
  - One `prev` register per source.
  - A rise is `req & ~prev`.
  - A request held high sets IF only once.
- Bus write: when `WE` is high and `address` equals `IF_ADDR`, IF ← `databus[4:0]`. When `address` equals `IE_ADDR`, IE ← `databus`. The write takes effect at the clock edge.
- Bus read: when `RE` is high and `WE` is low and the address matches, the block drives `databus` combinationally:
  - IF reads as {3'b111, IF[4:0]}.
  - IE reads as IE.
  - Otherwise `databus` is 8'bz.
  - The block never drives `databus` while `WE` is high.
- Acknowledge: on a cycle with `int_clear` high, compute `pend = IF & IE[4:0]` and clear the lowest-index set bit of `pend`. If `pend` is 0, there is no effect.
- Next-IF precedence, lowest to highest:
  1. Hold.
  2. Acknowledge clear.
  3. Bus write to IF (replaces the hold/clear result entirely).
  4. OR in this cycle's rising edges.
- Consequences of the precedence:
  - A new edge on the same bit that is being cleared or written to 0 leaves that bit set.
  - A write to IF and `int_clear` in the same cycle: the write wins, and the clear is discarded.
- The acknowledge selection uses the pre-edge IF value. Priority is evaluated on registered state only.

## Timing
- Reset values: IF = 5'b0, IE = 8'h00, all `prev` = 0. All `*_int` outputs are 0, `int_en` is 8'h00, `databus` is z.
- A request that is high at the first edge after reset release counts as a rising edge.
- Edge to output latency is 1 cycle: a request rising before edge N gives `*_int` high after edge N.
- Bus write to visible output is 1 cycle.
- Bus read is 0 cycles (combinational) from `address`/`RE`.
- Acknowledge to flag drop is 1 cycle. Back-to-back `int_clear` pulses on consecutive cycles each clear one bit, in priority order.
- Reset asserted mid-operation clears everything asynchronously, including pending flags. There is no partial state.

## Structure
- The shared constants package holds:
  - `IF_ADDR` and `IE_ADDR` defaults.
  - An enum `int_src_t` {INT_VBLANK, INT_LCDC, INT_TIMER, INT_SERIAL, INT_JOYPAD} giving the bit indices.
  - `INT_COUNT` = 5.
- Sub-module `int_edge_detect`: parameterised width, registered `prev`, outputs a rise vector. It is instantiated once with width `INT_COUNT`.
- Priority clear is a small combinational lowest-set-bit isolate (`pend & -pend`) inside the top.

## Test plan
- Reset, then idle: `int_en` = 8'h00, all `*_int` = 0. A read of 0xFF0F returns 8'hE0; a read of 0xFFFF returns 8'h00.
- Raise `timer_req` and hold it for 10 cycles: `timer_int` goes 1 after the next edge and stays 1. `int_clear` with IE = 8'h04 drops it, and it does not re-set while the request stays high.
- Write IE = 8'h1F, then pulse vblank, serial and joypad: IF = 5'b11001. Three consecutive `int_clear` pulses clear bit 0, then bit 3, then bit 4.
- IE = 8'h02 with IF = 5'b00011: `int_clear` clears bit 1 only. vblank stays pending because it is disabled.
- Same cycle: `int_clear` targeting lcdc plus a new `lcdc_req` rising edge: `lcdc_int` stays 1. Same cycle: write IF = 8'h00 plus a `joypad_req` rise: IF = 5'b10000.
- Set IF = 5'b11111 and IE = 8'hFF, then assert `rst` asynchronously mid-cycle: all outputs are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: bus addresses, source
// indices and source count.
package interrupt_controller_pkg;

  localparam logic [15:0] IF_ADDR_DEFAULT = 16'hFF0F;
  localparam logic [15:0] IE_ADDR_DEFAULT = 16'hFFFF;
  localparam int          INT_COUNT       = 5;

  // Bit index of each source in IF/IE; lower index wins on acknowledge.
  typedef enum logic [2:0] {
    INT_VBLANK = 3'd0,
    INT_LCDC   = 3'd1,
    INT_TIMER  = 3'd2,
    INT_SERIAL = 3'd3,
    INT_JOYPAD = 3'd4
  } int_src_t;

endpackage

// File: rtl/int_edge_detect.sv
// Rising-edge detector on a vector of level requests; one registered prev
// bit per lane, so a held request produces a single-cycle rise.
module int_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= req;
  end

  assign rise = req & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: latches request edges into IF, holds IE,
// and clears the highest-priority enabled pending flag on CPU acknowledge.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [15:0] IF_ADDR = IF_ADDR_DEFAULT,
  parameter logic [15:0] IE_ADDR = IE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic        RE,
  input  logic [15:0] address,
  inout  wire  [7:0]  databus,
  input  logic        vblank_req,
  input  logic        lcdc_req,
  input  logic        timer_req,
  input  logic        serial_req,
  input  logic        joypad_req,
  input  logic        int_clear,
  output logic        vblank_int,
  output logic        lcdc_int,
  output logic        timer_int,
  output logic        serial_int,
  output logic        joypad_int,
  output logic [7:0]  int_en
);

  logic [INT_COUNT-1:0] req_vec;
  logic [INT_COUNT-1:0] rise;
  logic [INT_COUNT-1:0] if_q;
  logic [INT_COUNT-1:0] if_next;
  logic [INT_COUNT-1:0] pend;
  logic [INT_COUNT-1:0] clr_mask;
  logic [7:0]           ie_q;
  logic                 hit_if;
  logic                 hit_ie;
  logic                 rd_en;
  logic [7:0]           rd_data;

  assign req_vec = {joypad_req, serial_req, timer_req, lcdc_req, vblank_req};

  int_edge_detect #(.WIDTH(INT_COUNT)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .req  (req_vec),
    .rise (rise)
  );

  assign hit_if = (address == IF_ADDR);
  assign hit_ie = (address == IE_ADDR);

  // Lowest set bit of the enabled pending set, taken from registered IF only.
  assign pend     = if_q & ie_q[INT_COUNT-1:0];
  assign clr_mask = pend & (~pend + 1'b1);

  always_comb begin
    if_next = if_q;
    if (int_clear) if_next = if_q & ~clr_mask;
    if (WE && hit_if) if_next = databus[INT_COUNT-1:0];
    // New edges always survive a same-cycle clear or write.
    if_next = if_next | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_q <= '0;
      ie_q <= 8'h00;
    end else begin
      if_q <= if_next;
      if (WE && hit_ie) ie_q <= databus;
    end
  end

  assign rd_en   = RE && !WE && (hit_if || hit_ie);
  assign rd_data = hit_if ? {3'b111, if_q} : ie_q;
  assign databus = rd_en ? rd_data : 8'bz;

  assign vblank_int = if_q[INT_VBLANK];
  assign lcdc_int   = if_q[INT_LCDC];
  assign timer_int  = if_q[INT_TIMER];
  assign serial_int = if_q[INT_SERIAL];
  assign joypad_int = if_q[INT_JOYPAD];
  assign int_en     = ie_q;

endmodule
